// File: rtl/mux_nt1_arb_if.sv
// N-to-1 arbitrated mux channel bundle: N valid/ready producers and one registered consumer port.
// Latency: none (wires only).
// Backpressure: in_ready and out_ready carry the valid/ready handshake in each direction.
interface mux_nt1_arb_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    // Producer/consumer side: drives the input channels and the output ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Mux side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_nt1_arb.sv
// N-to-1 arbitrated mux: fixed-priority or round-robin choice among valid channels into one output register.
// Latency: 1 cycle from input handshake to out_valid; sustains 1 beat/cycle.
// Backpressure: output register reloads only when empty or draining; otherwise every in_ready is 0.
module mux_nt1_arb #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 1
) (
    input  logic           clk,
    input  logic           rst,
    mux_nt1_arb_if.slave   bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [W-1:0]     gnt_dat;
    logic             load;
    logic             xfer;
    logic [N-1:0]     rdy;

    logic             ov;
    logic [W-1:0]     od;
    logic [SEL_W-1:0] os;

    // Output register is free when empty or being drained this cycle.
    assign load = !ov || bus.out_ready;
    assign xfer = gnt_vld && load;

    // Search valid channels starting at ptr (round-robin) or at 0 (fixed priority); first hit wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 1) begin
                cand = SEL_W'((int'(ptr) + k) % N);
            end else begin
                cand = SEL_W'(k);
            end
            if (!gnt_vld && bus.in_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Pick the granted channel's data slice.
    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_dat = bus.in_data[i*W +: W];
            end
        end
    end

    // One-hot ready to the granted channel; forced low while in reset.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = !rst && xfer && (gnt_idx == SEL_W'(i));
        end
    end

    assign ptr_nxt = SEL_W'((int'(gnt_idx) + 1) % N);

    // Output register and round-robin pointer; ptr only moves on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov  <= 1'b0;
            od  <= '0;
            os  <= '0;
            ptr <= '0;
        end else begin
            if (xfer) begin
                ov <= 1'b1;
                od <= gnt_dat;
                os <= gnt_idx;
                if (MODE == 1) begin
                    ptr <= ptr_nxt;
                end
            end else if (bus.out_ready) begin
                ov <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.out_sel   = os;
endmodule

// File: doc/mux_nt1_arb.md
Name: mux_nt1_arb

Overview:
- Parametrised successor to the 2:1 1-bit mux: N input channels, W bits each, multiplexed onto one registered output channel.
- Selection is made by an internal arbiter (fixed-priority or round-robin), not by an external select input.
- Every channel uses a valid/ready handshake.
- Sits between multiple producers (e.g. DMA or request queues) and one shared consumer. Single clock domain.

Parameters:
- N, 4, number of input channels (legal range 1..16).
- W, 8, data width per channel in bits (legal range 1..64).
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W, derived as max(1, clog2(N)), width of out_sel. Localparam, not user-set.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  N  per-channel valid; bit i belongs to channel i
- in_data  in  N*W  packed data; channel i occupies bits [i*W +: W]
- in_ready  out  N  per-channel ready; at most one bit set in any cycle
- out_valid  out  1  output register holds a beat
- out_data  out  W  registered data of the held beat
- out_sel  out  SEL_W  index of the channel that supplied the held beat
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready

Behaviour:
- Reset:
  - While rst is high: out_valid=0, out_data=0, out_sel=0, RR pointer=0, in_ready=0 (forced).
  - Takes effect immediately when asserted (asynchronous).
  - Reset mid-transfer discards the held beat with no acceptance.
  - First grant is possible on the first clk edge after rst deasserts.
- Load enable: load = !out_valid || out_ready (the output register is empty or being drained this cycle).
- Arbitration (combinational, every cycle):
  - Candidate set = in_valid.
  - MODE 0: grant the lowest index i with in_valid[i]=1.
  - MODE 1: grant the first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- in_ready:
  - in_ready[g]=1 only if load=1 and channel g is granted. All other bits are 0.
  - in_ready never depends on in_valid of the same channel except through arbitration. No combinational path from in_data.
- Transfer on channel g at a clk edge when in_valid[g] && in_ready[g]:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - MODE 1 only: ptr <= (g+1) mod N, wrapping N-1 to 0.
  - ptr holds when no transfer occurs, including when the output is stalled.
- Drain: out_valid && out_ready with no new transfer -> out_valid <= 0; out_data and out_sel hold their last values.
- Simultaneous drain and load: the new beat replaces the old in the same edge. out_valid stays 1. Sustained throughput is 1 beat/cycle.
- Stall: out_valid && !out_ready -> out_valid, out_data and out_sel are stable, and all in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- Producer rule: once in_valid[i] is asserted, it holds with stable data until accepted. The block does not check this.
- N=1: arbiter degenerates to a pass-through, out_sel is constant 0, and ptr is unused.
- Ordering: beats from one channel stay in order. No ordering guarantee across channels beyond the arbitration policy.
- No beat is ever duplicated or dropped outside reset.

Test Plan:
- Reset/idle (N=4, W=8, MODE=1): hold rst 3 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. First edge after release grants ch0; next cycle out_valid=1, out_sel=0.
- Round-robin fairness: all 4 channels continuously valid (ch i data = 8'hA0+i), out_ready=1 -> out_sel sequence 0,1,2,3,0,1,..., one beat per cycle, each data matching its channel.
- Fixed priority (MODE=0): in_valid=4'b1010 constantly, out_ready=1 -> out_sel=1 every beat and ch3 is never granted. Drop ch1 -> ch3 is granted on the next cycle.
- Back-pressure: out_ready=0 for 5 cycles while ch2 holds 8'h5C -> one beat is captured, out_data stays 8'h5C, in_ready=0 throughout, and ptr is unchanged. Raise out_ready -> the beat drains, and the next grant starts the search from ch3.
- Wrap and sparse: ptr=3 with only ch0 and ch3 valid -> ch3 is granted, then ch0 (wrap). Then only ch1 valid -> ch1 is granted with no idle bubble.
- Async reset mid-stall: assert rst between edges while out_valid=1 -> out_valid=0 immediately. After release the held beat is not re-presented, and arbitration restarts at ch0.
